stack_mlane: RTL and testbench
==============================

Name: stack_mlane

Overview:
- Parametrised successor to the Sephirot eBPF stack memory: NLANES read and NLANES write lanes, one per VLIW lane, over a DEPTH x DATAW flop array.
- Adds byte-strobed writes for eBPF 1/2/4/8-byte stores.
- Adds deterministic same-cycle write collision resolution and write-first read forwarding.
- Adds a post-reset zero-clear sequence so every program starts on a clean stack.

Parameters:
- NLANES, 4, number of read lanes and of write lanes.
- DATAW, 64, entry width in bits; must be a multiple of 8.
- DEPTH, 64, number of entries; must be a power of two.
- ADDRW, 16, width of each lane's entry address port (entry index, not byte address).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- rd_addr  in  NLANES*ADDRW  packed read addresses; lane i at [i*ADDRW +: ADDRW].
- rd_data  out  NLANES*DATAW  registered read data; lane i at [i*DATAW +: DATAW].
- wr_en  in  NLANES  per-lane write enable.
- wr_addr  in  NLANES*ADDRW  packed write addresses.
- wr_data  in  NLANES*DATAW  packed write data.
- wr_strb  in  NLANES*DATAW/8  per-lane byte enables; bit b selects data byte b.
- init_busy  out  1  high while the clear sequence runs.
- bound_err  out  1  sticky out-of-range flag (see Optional Feature).

Behaviour:
- Reset (reset==0 at a clk edge):
  - rd_data=0, init_busy=1, bound_err=0.
  - FSM enters CLEAR with clr_ptr=0.
  - Array contents are not reset directly.
- FSM states: CLEAR and RUN.
  - CLEAR: each cycle writes 0 to entry clr_ptr, then clr_ptr++. The transition to RUN happens on the cycle clr_ptr==DEPTH-1 is written.
  - The clear sequence takes DEPTH cycles after reset is released.
  - init_busy=1 throughout CLEAR and falls on the first RUN cycle.
  - In CLEAR, user writes are dropped and rd_data is held at 0.
  - Reset asserted mid-CLEAR or mid-RUN restarts CLEAR from 0.
- Address mapping: the effective index is addr[log2(DEPTH)-1:0], so addresses wrap modulo DEPTH.
- Read latency is 1 cycle: rd_data lane i at cycle t+1 reflects rd_addr lane i sampled at t.
- Write: byte b of entry A is updated at the edge when wr_en[i]=1, eff(wr_addr[i])==A and wr_strb[i][b]=1.
- Collision (two or more lanes hitting the same entry in one cycle): resolved per byte; the highest-indexed lane with its strobe set wins. Non-strobed bytes keep their old value.
- Read-during-write, same entry, same cycle: rd_data returns the post-write merged value (write-first, per byte, including collision resolution).
- Multiple read lanes may read the same entry in the same cycle with no restriction.
- wr_strb==0 with wr_en==1 is legal and performs no update.

Optional Feature:
- Macro: STACK_BOUNDS_CHECK_EN.
- Defined:
  - Any enabled write lane, or any read lane, with address >= DEPTH sets bound_err=1 at the next edge. The flag holds until reset.
  - Offending writes are suppressed.
  - Offending reads return 0.
  - Checks apply in RUN only.
- Not defined:
  - bound_err is tied to 0.
  - Addresses wrap silently, as described under Behaviour.

Decomposition:
- Package stack_pkg holds:
  - clog2 constant function;
  - FSM state enum {ST_CLEAR, ST_RUN};
  - localparam BYTES=DATAW/8.
- Sub-module stack_wr_merge, purely combinational: given one entry index, its current value and all lane write inputs, it produces the per-byte merged next value and a hit flag.
  - The top level instantiates one per entry for array update.
  - The same logic is reused per read lane for write-first forwarding.
- FSM, array and read registers live in stack_mlane.

Test Plan:
1. Reset, then release -> init_busy=1 for exactly 64 cycles. rd_data=0 throughout, and a write issued in that window is dropped: a later read of the same address returns 0.
2. In RUN, lane0 writes addr 5 = 0x1122334455667788 with strb 0xFF; next cycle lanes 0..3 all read addr 5 -> all four lanes return 0x1122334455667788 one cycle later.
3. Collision on entry 3 = 0: lane1 writes 0xAAAA… strb 0x0F and lane2 writes 0xBBBB… strb 0x03 -> entry 3 = 0x00000000AAAABBBB.
4. Same-cycle lane3 write addr 7 = 0xDEADBEEF00000000 strb 0xF0 and lane0 read addr 7 (entry was 0x0000000012345678) -> rd_data lane0 = 0xDEADBEEF12345678 next cycle.
5. Write addr 70 with DEPTH 64:
   - macro off -> entry 6 is updated and bound_err stays 0;
   - macro on -> no entry changes, bound_err=1, and it stays 1 until reset.
6. Reset asserted mid-RUN after entries are written -> rd_data=0 next cycle, init_busy=1 for 64 cycles, then all entries read 0.

Source files
------------

// File: rtl/stack_mlane_pkg.sv
// Shared definitions for the multi-lane eBPF stack memory.
package stack_pkg;

  localparam int DATAW_DFLT = 64;
  localparam int BYTES      = DATAW_DFLT / 8;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  // Bits needed to index v entries (v >= 2).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/stack_mlane_if.sv
// Lane bus of the stack memory: packed per-lane read/write ports plus status.
interface stack_mlane_if #(
  parameter int NLANES = 4,
  parameter int DATAW  = 64,
  parameter int ADDRW  = 16
);
  logic [NLANES*ADDRW-1:0]   rd_addr;
  logic [NLANES*DATAW-1:0]   rd_data;
  logic [NLANES-1:0]         wr_en;
  logic [NLANES*ADDRW-1:0]   wr_addr;
  logic [NLANES*DATAW-1:0]   wr_data;
  logic [NLANES*DATAW/8-1:0] wr_strb;
  logic                      init_busy;
  logic                      bound_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_strb,
    input  rd_data, init_busy, bound_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_strb,
    output rd_data, init_busy, bound_err
  );
endinterface

// File: rtl/stack_wr_merge.sv
// Per-byte merge of all write lanes onto one entry. Lanes are scanned in
// ascending order so the highest-indexed lane with its strobe set wins.
module stack_wr_merge #(
  parameter int NLANES = 4,
  parameter int DATAW  = 64,
  parameter int ADDRW  = 16,
  parameter int IDXW   = 6
) (
  input  logic [IDXW-1:0]           idx,
  input  logic [DATAW-1:0]          cur,
  input  logic [NLANES-1:0]         wr_en,
  input  logic [NLANES*ADDRW-1:0]   wr_addr,
  input  logic [NLANES*DATAW-1:0]   wr_data,
  input  logic [NLANES*DATAW/8-1:0] wr_strb,
  output logic [DATAW-1:0]          nxt,
  output logic                      hit
);
  localparam int NB = DATAW / 8;

  // Upper address bits only matter to the bounds check at the top level.
  logic unused_addr_hi;
  assign unused_addr_hi = ^wr_addr;

  // Later lanes overwrite earlier ones byte by byte.
  always_comb begin
    nxt = cur;
    hit = 1'b0;
    for (int l = 0; l < NLANES; l++) begin
      if (wr_en[l] && (wr_addr[l*ADDRW +: IDXW] == idx)) begin
        hit = 1'b1;
        for (int b = 0; b < NB; b++)
          if (wr_strb[l*NB + b]) nxt[b*8 +: 8] = wr_data[l*DATAW + b*8 +: 8];
      end
    end
  end
endmodule

// File: rtl/stack_mlane.sv
// Multi-lane eBPF stack memory: NLANES read + NLANES byte-strobed write
// lanes over a DEPTH x DATAW flop array, write-first forwarding, and a
// zero-clear sweep after every reset.
// Optional: STACK_BOUNDS_CHECK_EN flags/suppresses addresses >= DEPTH.
module stack_mlane
  import stack_pkg::*;
#(
  parameter int NLANES = 4,
  parameter int DATAW  = 64,
  parameter int DEPTH  = 64,
  parameter int ADDRW  = 16
) (
  input logic         clk,
  input logic         reset,
  stack_mlane_if.slave bus
);
  localparam int IDXW = clog2(DEPTH);

  state_e                        state_q, state_d;
  logic [IDXW-1:0]               clr_ptr_q, clr_ptr_d;
  logic                          run;
  logic [DEPTH-1:0][DATAW-1:0]   mem, mem_nxt;
  logic [DEPTH-1:0]              mem_hit;
  logic [NLANES-1:0]             oob_w, oob_r, wr_en_g;
  logic [NLANES-1:0][IDXW-1:0]   ridx;
  logic [NLANES-1:0][DATAW-1:0]  rd_fwd, rd_q;
  logic [NLANES-1:0]             rd_hit_unused;

  // State register; reset restarts the clear sweep from entry 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state: sweep every entry once, leave CLEAR as the last one is written.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == IDXW'(DEPTH - 1)) state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  assign run           = (state_q == ST_RUN);
  assign bus.init_busy = (state_q == ST_CLEAR);

`ifdef STACK_BOUNDS_CHECK_EN
  logic bound_err_q;

  for (genvar i = 0; i < NLANES; i++) begin : g_oob
    assign oob_w[i] = bus.wr_en[i] && (32'(bus.wr_addr[i*ADDRW +: ADDRW]) >= DEPTH);
    assign oob_r[i] = (32'(bus.rd_addr[i*ADDRW +: ADDRW]) >= DEPTH);
  end

  // Sticky flag; only RUN-state accesses count.
  always_ff @(posedge clk) begin
    if (!reset)                    bound_err_q <= 1'b0;
    else if (run && |{oob_w, oob_r}) bound_err_q <= 1'b1;
  end
  assign bus.bound_err = bound_err_q;
`else
  // Addresses wrap modulo DEPTH; upper bits are ignored.
  logic unused_rd_hi;
  assign unused_rd_hi  = ^bus.rd_addr;
  assign oob_w         = '0;
  assign oob_r         = '0;
  assign bus.bound_err = 1'b0;
`endif

  assign wr_en_g = run ? (bus.wr_en & ~oob_w) : '0;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    stack_wr_merge #(.NLANES(NLANES), .DATAW(DATAW), .ADDRW(ADDRW), .IDXW(IDXW)) u_merge (
      .idx     (IDXW'(e)),
      .cur     (mem[e]),
      .wr_en   (wr_en_g),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .wr_strb (bus.wr_strb),
      .nxt     (mem_nxt[e]),
      .hit     (mem_hit[e])
    );
  end

  // Array update: zero sweep in CLEAR, merged lane writes in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_q == ST_CLEAR) mem[clr_ptr_q] <= '0;
      else
        for (int e = 0; e < DEPTH; e++)
          if (mem_hit[e]) mem[e] <= mem_nxt[e];
    end
  end

  // Read side reuses the merge so a same-cycle write is seen (write-first).
  for (genvar i = 0; i < NLANES; i++) begin : g_rd
    assign ridx[i] = bus.rd_addr[i*ADDRW +: IDXW];
    stack_wr_merge #(.NLANES(NLANES), .DATAW(DATAW), .ADDRW(ADDRW), .IDXW(IDXW)) u_fwd (
      .idx     (ridx[i]),
      .cur     (mem[ridx[i]]),
      .wr_en   (wr_en_g),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .wr_strb (bus.wr_strb),
      .nxt     (rd_fwd[i]),
      .hit     (rd_hit_unused[i])
    );
  end

  // Registered read data; zero outside RUN and for out-of-range reads.
  always_ff @(posedge clk) begin
    if (!reset) rd_q <= '0;
    else
      for (int i = 0; i < NLANES; i++)
        rd_q[i] <= (run && !oob_r[i]) ? rd_fwd[i] : '0;
  end

  assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_stack_mlane.sv
// Directed bench for stack_mlane (default config: 4 lanes, 64b, 64 entries).
module tb_stack_mlane;
  localparam int NL = 4;
  localparam int DW = 64;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  stack_mlane_if #(.NLANES(NL), .DATAW(DW), .ADDRW(AW)) bus ();
  stack_mlane #(.NLANES(NL), .DATAW(DW), .DEPTH(64), .ADDRW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en   = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_strb = '0;
    bus.rd_addr = '0;
  endtask

  task automatic wr(input int l, input logic [15:0] a, input logic [63:0] d, input logic [7:0] s);
    bus.wr_en[l]           = 1'b1;
    bus.wr_addr[l*AW +: AW] = a;
    bus.wr_data[l*DW +: DW] = d;
    bus.wr_strb[l*8 +: 8]   = s;
  endtask

  task automatic rd_all(input logic [15:0] a);
    for (int l = 0; l < NL; l++) bus.rd_addr[l*AW +: AW] = a;
  endtask

  function automatic logic [63:0] rdl(input int l);
    return bus.rd_data[l*DW +: DW];
  endfunction

  // Counts cycles of init_busy from reset release; checks rd_data stays 0.
  task automatic clear_window(input string tag, input bit poke);
    int cnt;
    logic [DW*NL-1:0] acc;
    cnt = 0;
    acc = '0;
    while (bus.init_busy === 1'b1 && cnt < 200) begin
      acc |= bus.rd_data;
      if (poke && cnt == 10) begin
        wr(0, 16'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        rd_all(16'd9);
      end
      if (poke && cnt == 11) bus.wr_en = '0;
      tick();
      cnt++;
    end
    chk({tag, "_busy_cycles"}, 64'(cnt), 64'd64);
    chk({tag, "_rd_zero"}, 64'(|acc), 64'd0);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(bus.init_busy), 64'd1);
    chk("rst_rd", 64'(|bus.rd_data), 64'd0);
    chk("rst_berr", 64'(bus.bound_err), 64'd0);

    // 1: clear window, write inside it is dropped
    reset = 1'b1;
    clear_window("clr1", 1'b1);
    idle();
    rd_all(16'd9);
    tick();
    chk("drop_wr", rdl(0), 64'd0);

    // 2: broadcast read
    idle();
    wr(0, 16'd5, 64'h1122334455667788, 8'hFF);
    tick();
    idle();
    rd_all(16'd5);
    tick();
    for (int l = 0; l < NL; l++) chk($sformatf("bcast_l%0d", l), rdl(l), 64'h1122334455667788);

    // 3: per-byte collision, highest lane wins
    idle();
    wr(1, 16'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    wr(2, 16'd3, 64'hBBBB_BBBB_BBBB_BBBB, 8'h03);
    tick();
    idle();
    rd_all(16'd3);
    tick();
    chk("collide", rdl(2), 64'h00000000AAAABBBB);

    // 4: write-first forwarding
    idle();
    wr(0, 16'd7, 64'h0000000012345678, 8'hFF);
    tick();
    idle();
    wr(3, 16'd7, 64'hDEADBEEF00000000, 8'hF0);
    rd_all(16'd7);
    tick();
    chk("fwd_l0", rdl(0), 64'hDEADBEEF12345678);
    chk("fwd_l3", rdl(3), 64'hDEADBEEF12345678);

    // zero strobe is a no-op
    idle();
    wr(0, 16'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    rd_all(16'd7);
    tick();
    chk("strb0_fwd", rdl(1), 64'hDEADBEEF12345678);
    idle();
    rd_all(16'd7);
    tick();
    chk("strb0_mem", rdl(1), 64'hDEADBEEF12345678);

    // forwarding with a same-cycle collision on a partial strobe
    idle();
    wr(0, 16'd7, 64'h1111_1111_1111_1111, 8'h81);
    wr(2, 16'd7, 64'h2222_2222_2222_2222, 8'h01);
    rd_all(16'd7);
    tick();
    chk("fwd_collide", rdl(0), 64'h11ADBEEF12345622);

    // 5: out-of-range write
    idle();
    wr(0, 16'd70, 64'h0606_0606_0606_0606, 8'hFF);
    tick();
    idle();
    rd_all(16'd6);
    tick();
`ifdef STACK_BOUNDS_CHECK_EN
    chk("oob_entry6", rdl(0), 64'd0);
    chk("oob_berr", 64'(bus.bound_err), 64'd1);
    tick();
    tick();
    chk("oob_berr_sticky", 64'(bus.bound_err), 64'd1);
    rd_all(16'd69);
    tick();
    chk("oob_rd_zero", rdl(0), 64'd0);
`else
    chk("wrap_entry6", rdl(0), 64'h0606_0606_0606_0606);
    chk("wrap_berr", 64'(bus.bound_err), 64'd0);
    rd_all(16'd69);
    tick();
    chk("wrap_rd69", rdl(0), 64'h1122334455667788);
`endif

    // 6: reset mid-RUN wipes everything
    idle();
    rd_all(16'd5);
    reset = 1'b0;
    tick();
    chk("rst2_rd", rdl(0), 64'd0);
    chk("rst2_busy", 64'(bus.init_busy), 64'd1);
    chk("rst2_berr", 64'(bus.bound_err), 64'd0);
    reset = 1'b1;
    clear_window("clr2", 1'b0);
    for (int g = 0; g < 16; g++) begin
      for (int l = 0; l < NL; l++) bus.rd_addr[l*AW +: AW] = 16'(g*4 + l);
      tick();
      chk($sformatf("zero_grp%0d", g), 64'(|bus.rd_data), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
